// File: rtl/instr_encoder_if.sv
// Request/write-side signal bundle for instr_encoder.
// The master modport drives encode requests; the slave modport is the encoder itself.
interface instr_encoder_if;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic        stop_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [3:0]  req_kind_i;
    logic [4:0]  rs_i;
    logic [4:0]  rt_i;
    logic [4:0]  rd_i;
    logic [15:0] imm_i;
    logic        mem_busy_i;
    logic        wr_en_o;
    logic [31:0] wr_addr_o;
    logic [31:0] wr_data_o;
    logic        err_o;
    logic        done_o;
    logic [15:0] count_o;

    modport master (
        output start_i, base_addr_i, stop_i, req_valid_i, req_kind_i,
               rs_i, rt_i, rd_i, imm_i, mem_busy_i,
        input  req_ready_o, wr_en_o, wr_addr_o, wr_data_o, err_o, done_o, count_o
    );

    modport slave (
        input  start_i, base_addr_i, stop_i, req_valid_i, req_kind_i,
               rs_i, rt_i, rd_i, imm_i, mem_busy_i,
        output req_ready_o, wr_en_o, wr_addr_o, wr_data_o, err_o, done_o, count_o
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes R/I-type requests into MIPS-style words, buffers them in a 4-entry FIFO and writes them
// to instruction memory. Define ENC_NOP_PAD_EN to follow every branch with a delay-slot NOP.
module instr_encoder (
    input  logic           clk_i,
    input  logic           rst_i,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

`ifdef ENC_NOP_PAD_EN
    localparam logic [2:0] ReadyLimit = 3'd2;
`else
    localparam logic [2:0] ReadyLimit = 3'd3;
`endif

    state_t      state;
    state_t      state_next;
    logic [31:0] fifo_mem [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  occupancy;
    logic [31:0] addr;
    logic [15:0] count;
    logic        err_q;
    logic        done;

    logic [31:0] word;
    logic        legal;
    logic        ready;
    logic        accept;
    logic        push;
    logic        pad;
    logic        pop;
    logic [1:0]  push_words;

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (bus.req_kind_i)
            4'd0:    word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'b100000};
            4'd1:    word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'b100010};
            4'd2:    word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'b100100};
            4'd3:    word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'b100101};
            4'd4:    word = {6'b000000, bus.rs_i, bus.rt_i, bus.rd_i, 5'd0, 6'b101010};
            4'd5:    word = {6'b001000, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd6:    word = {6'b001010, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd7:    word = {6'b000100, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd8:    word = {6'b000101, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd9:    word = {6'b000001, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd10:   word = {6'b000111, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd11:   word = {6'b100011, bus.rs_i, bus.rt_i, bus.imm_i};
            4'd12:   word = {6'b101011, bus.rs_i, bus.rt_i, bus.imm_i};
            default: legal = 1'b0;
        endcase
    end

    // Illegal kinds still complete the handshake; they just never reach the FIFO.
    assign ready  = (state == RUN) && (occupancy <= ReadyLimit);
    assign accept = bus.req_valid_i && ready;
    assign push   = accept && legal;
`ifdef ENC_NOP_PAD_EN
    assign pad    = push && (bus.req_kind_i >= 4'd7) && (bus.req_kind_i <= 4'd10);
`else
    assign pad    = 1'b0;
`endif
    assign push_words = {1'b0, push} + {1'b0, pad};
    assign pop        = (state != IDLE) && (occupancy != 3'd0) && !bus.mem_busy_i;

    // A start in any state restarts the run; DRAIN ends in the cycle its last word leaves.
    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_i) state_next = RUN;
            end
            RUN: begin
                if (!bus.start_i && bus.stop_i) state_next = DRAIN;
            end
            DRAIN: begin
                if (bus.start_i) begin
                    state_next = RUN;
                end else if (occupancy == 3'd0 || (occupancy == 3'd1 && pop)) begin
                    state_next = IDLE;
                    done       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= word;
        if (pad)  fifo_mem[wr_ptr + 2'd1] <= '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
            addr      <= '0;
            count     <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= accept && !legal;
            if (bus.start_i) begin
                rd_ptr    <= '0;
                wr_ptr    <= '0;
                occupancy <= '0;
                addr      <= bus.base_addr_i;
                count     <= '0;
            end else begin
                wr_ptr    <= wr_ptr + push_words;
                occupancy <= occupancy + {1'b0, push_words} - {2'b00, pop};
                if (pop) begin
                    rd_ptr <= rd_ptr + 2'd1;
                    addr   <= addr + 32'd4;
                    count  <= count + 16'd1;
                end
            end
        end
    end

    assign bus.req_ready_o = ready;
    assign bus.wr_en_o     = pop;
    assign bus.wr_addr_o   = addr;
    assign bus.wr_data_o   = fifo_mem[rd_ptr];
    assign bus.err_o       = err_q;
    assign bus.done_o      = done;
    assign bus.count_o     = count;
endmodule
